// File: rtl/cla_pipe_addsub.sv
// cla_pipe_addsub: pipelined carry-lookahead adder/subtractor.
// The WIDTH-bit add is cut into 4-bit lookahead blocks. Each pipeline stage
// resolves BPS consecutive blocks with a block-level lookahead carry unit and
// passes its carry, partial sum and the still-unprocessed operand bits to the
// next stage. Both sides use valid/ready; bubbles collapse and a stalled stage
// holds its contents.
// Legal parameters: WIDTH % 4 == 0, 1 <= STAGES <= WIDTH/4, (WIDTH/4) % STAGES == 0.
module cla_pipe_addsub #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NB  = WIDTH / 4;          // number of 4-bit lookahead blocks
   localparam int BPS = NB / STAGES;        // blocks resolved per stage
   localparam int SW  = 4 * BPS;            // bits resolved per stage
   localparam int OS  = (STAGES > 1) ? STAGES - 1 : 1;  // stages that forward operands

   // Result of one stage's slice of the addition.
   typedef struct packed {
      logic [WIDTH-1:0] sum;   // incoming partial sum with this stage's bits filled in
      logic             cout;  // carry out of the stage's top block
      logic             cmsb;  // carry into the top bit of the stage's top block
   } stage_res_t;

   // Resolve blocks starting at bit 'lo': block P/G terms, a lookahead unit
   // across the blocks of the stage, then bit-level lookahead inside each block.
   function automatic stage_res_t stage_calc(
      input logic [WIDTH-1:0] av,
      input logic [WIDTH-1:0] bv,
      input logic [WIDTH-1:0] acc,
      input logic             c0,
      input int               lo
   );
      stage_res_t     r;
      logic [3:0]     p;
      logic [3:0]     g;
      logic [3:0]     c;
      logic [BPS-1:0] bp;
      logic [BPS-1:0] bg;
      logic [BPS:0]   bc;
      logic           t;
      r.sum  = acc;
      r.cout = 1'b0;
      r.cmsb = 1'b0;
      // Block propagate / generate.
      for (int j = 0; j < BPS; j++) begin
         p     = av[lo + 4*j +: 4] ^ bv[lo + 4*j +: 4];
         g     = av[lo + 4*j +: 4] & bv[lo + 4*j +: 4];
         bp[j] = &p;
         bg[j] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
      end
      // Lookahead carry unit: every block carry-in in sum-of-products form.
      bc    = '0;
      bc[0] = c0;
      for (int j = 1; j <= BPS; j++) begin
         t = c0;
         for (int k = 0; k < j; k++) t = t & bp[k];
         bc[j] = t;
         for (int i = 0; i < j; i++) begin
            t = bg[i];
            for (int k = i + 1; k < j; k++) t = t & bp[k];
            bc[j] = bc[j] | t;
         end
      end
      // Bit carries and sum bits inside each block.
      for (int j = 0; j < BPS; j++) begin
         p    = av[lo + 4*j +: 4] ^ bv[lo + 4*j +: 4];
         g    = av[lo + 4*j +: 4] & bv[lo + 4*j +: 4];
         c[0] = bc[j];
         c[1] = g[0] | (p[0] & c[0]);
         c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
         c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
         r.sum[lo + 4*j +: 4] = p ^ c;
         if (j == BPS - 1) r.cmsb = c[3];
      end
      r.cout = bc[BPS];
      return r;
   endfunction

   // Pipeline state.
   logic [STAGES-1:0] v_q;              // stage holds a beat
   logic [STAGES-1:0] c_q;              // carry out of the stage's top block
   logic [WIDTH-1:0]  sum_q [STAGES];   // partial sum accumulated so far
   logic [WIDTH-1:0]  a_q   [OS];       // operand A forwarded to the next stage
   logic [WIDTH-1:0]  b_q   [OS];       // operand B' (already inverted for sub)
   logic              cmsb_q;           // carry into the MSB, for overflow

   // Stage inputs and results.
   logic [WIDTH-1:0]  st_a   [STAGES];
   logic [WIDTH-1:0]  st_b   [STAGES];
   logic [WIDTH-1:0]  st_acc [STAGES];
   logic [STAGES-1:0] st_c;
   logic [STAGES-1:0] st_v;
   stage_res_t        res    [STAGES];
   logic [STAGES:0]   rdy;              // rdy[s]: stage s may load this cycle

   // Stage input selection and per-stage arithmetic.
   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      if (s == 0) begin : g_first
         assign st_a[s]   = a;
         assign st_b[s]   = sub ? ~b : b;
         assign st_acc[s] = '0;
         assign st_c[s]   = sub ? 1'b1 : cin;
         assign st_v[s]   = in_valid;
      end else begin : g_next
         assign st_a[s]   = a_q[s-1];
         assign st_b[s]   = b_q[s-1];
         assign st_acc[s] = sum_q[s-1];
         assign st_c[s]   = c_q[s-1];
         assign st_v[s]   = v_q[s-1];
      end
      assign res[s] = stage_calc(st_a[s], st_b[s], st_acc[s], st_c[s], s * SW);
   end

   // Stall chain: a stage can load when empty or when its successor can load.
   always_comb begin
      // NOTE: assign every bit a default first so no path leaves rdy unassigned (no latch).
      rdy         = '0;
      rdy[STAGES] = out_ready;
      for (int s = STAGES - 1; s >= 0; s--) rdy[s] = ~v_q[s] | rdy[s+1];
   end

   assign in_ready = rdy[0] & ~rst;

   // Pipeline registers: advance each stage that can load, hold otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: only valid bits and the output-facing registers need reset; the
         // datapath registers are qualified by valid and keep their contents.
         v_q                <= '0;
         c_q                <= '0;
         cmsb_q             <= 1'b0;
         sum_q[STAGES-1]    <= '0;
      end else begin
         // NOTE: non-blocking updates so every stage samples the pre-edge state of its predecessor.
         for (int s = 0; s < STAGES; s++) begin
            if (rdy[s]) begin
               v_q[s] <= st_v[s];
               if (st_v[s]) begin
                  sum_q[s] <= res[s].sum;
                  c_q[s]   <= res[s].cout;
               end
            end
         end
         for (int s = 0; s < STAGES - 1; s++) begin
            if (rdy[s] && st_v[s]) begin
               a_q[s] <= st_a[s];
               b_q[s] <= st_b[s];
            end
         end
         if (rdy[STAGES-1] && st_v[STAGES-1]) cmsb_q <= res[STAGES-1].cmsb;
      end
   end

   assign out_valid = v_q[STAGES-1];
   assign sum       = sum_q[STAGES-1];
   assign cout      = c_q[STAGES-1];
   assign ovf       = c_q[STAGES-1] ^ cmsb_q;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Directed bench for cla_pipe_addsub (WIDTH=16, STAGES=2) with a short
// randomised stream checked against an arithmetic model.
module tb_cla_pipe_addsub;

   localparam int WIDTH  = 16;
   localparam int STAGES = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             cin = 1'b0;
   logic             sub = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          acc_cyc = 0;
   logic [17:0] exp_cur = '0;
   logic [17:0] exp_q[$];
   int          xfer_cyc[$];
   logic        hold_prev = 1'b0;
   logic [17:0] held = '0;
   logic        rand_done = 1'b0;

   cla_pipe_addsub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [17:0] pk(input logic [15:0] s, input logic c, input logic o);
      return {o, c, s};
   endfunction

   // Independent arithmetic model: full-precision add, overflow from operand signs.
   function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                         input logic ci, input logic s);
      logic [15:0] yb;
      logic [16:0] full;
      logic        o;
      yb   = s ? ~y : y;
      full = {1'b0, x} + {1'b0, yb} + {16'd0, (s ? 1'b1 : ci)};
      o    = (x[15] == yb[15]) && (full[15] != x[15]);
      return {o, full[16], full[15:0]};
   endfunction

   // Monitor: scoreboard push on accept, compare on transfer, hold check on stall.
   always @(negedge clk) begin
      if (rst) begin
         hold_prev = 1'b0;
      end else begin
         if (hold_prev) begin
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_data", {14'd0, ovf, cout, sum}, {14'd0, held});
         end
         if (out_valid && out_ready) begin
            xfer_cyc.push_back(cyc);
            if (exp_q.size() == 0) check("spurious_out", 32'd1, 32'd0);
            else check("result", {14'd0, ovf, cout, sum}, {14'd0, exp_q.pop_front()});
         end
         if (in_valid && in_ready) exp_q.push_back(exp_cur);
         hold_prev = out_valid && !out_ready;
         held      = {ovf, cout, sum};
      end
   end

   task automatic wait_accept();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 100);
      if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
      else acc_cyc = cyc;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send(input logic [15:0] x, input logic [15:0] y, input logic ci,
                       input logic s, input logic [17:0] e);
      a        = x;
      b        = y;
      cin      = ci;
      sub      = s;
      exp_cur  = e;
      in_valid = 1'b1;
      wait_accept();
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("drain_empty", exp_q.size(), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_outputs", {14'd0, ovf, cout, sum}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;

      // 1: wrap to zero with carry, latency check.
      out_ready = 1'b1;
      send(16'hFFFF, 16'h0001, 1'b0, 1'b0, pk(16'h0000, 1'b1, 1'b0));
      begin
         int n = 0;
         while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
         end
      end
      check("latency", cyc - acc_cyc, STAGES);
      drain();

      // 2: subtraction with and without borrow; 3: carry across blocks/stages.
      send(16'h8000, 16'h0001, 1'b0, 1'b1, pk(16'h7FFF, 1'b1, 1'b1));
      send(16'h0000, 16'h0001, 1'b0, 1'b1, pk(16'hFFFF, 1'b0, 1'b0));
      send(16'h7FFF, 16'h0001, 1'b1, 1'b0, pk(16'h8001, 1'b0, 1'b1));
      drain();

      // 4: eight back-to-back beats, no backpressure.
      xfer_cyc.delete();
      begin
         int t0;
         t0 = cyc;
         send(16'h0001, 16'h0001, 1'b0, 1'b0, pk(16'h0002, 1'b0, 1'b0));
         send(16'h1234, 16'h4321, 1'b0, 1'b0, pk(16'h5555, 1'b0, 1'b0));
         send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, pk(16'hFFFF, 1'b1, 1'b0));
         send(16'h8000, 16'h8000, 1'b0, 1'b0, pk(16'h0000, 1'b1, 1'b1));
         send(16'h0005, 16'h0003, 1'b1, 1'b1, pk(16'h0002, 1'b1, 1'b0));
         send(16'h0003, 16'h0005, 1'b0, 1'b1, pk(16'hFFFE, 1'b0, 1'b0));
         send(16'h7FFF, 16'hFFFF, 1'b0, 1'b1, pk(16'h8000, 1'b0, 1'b1));
         send(16'h00FF, 16'h0F01, 1'b0, 1'b0, pk(16'h1000, 1'b0, 1'b0));
         check("b2b_accept_cycles", cyc - t0, 32'd8);
      end
      drain();
      check("b2b_count", xfer_cyc.size(), 32'd8);
      if (xfer_cyc.size() == 8) check("b2b_consecutive", xfer_cyc[7] - xfer_cyc[0], 32'd7);

      // 5: backpressure for four cycles with the pipeline full.
      xfer_cyc.delete();
      out_ready = 1'b0;
      send(16'h1111, 16'h2222, 1'b0, 1'b0, pk(16'h3333, 1'b0, 1'b0));
      send(16'h0010, 16'h0020, 1'b0, 1'b1, pk(16'hFFF0, 1'b0, 1'b0));
      a        = 16'h8000;
      b        = 16'hFFFF;
      cin      = 1'b0;
      sub      = 1'b0;
      exp_cur  = pk(16'h7FFF, 1'b1, 1'b1);
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("stall_in_ready", {31'd0, in_ready}, 32'd0);
         check("stall_out_valid", {31'd0, out_valid}, 32'd1);
         check("stall_head", {14'd0, ovf, cout, sum}, {14'd0, pk(16'h3333, 1'b0, 1'b0)});
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      wait_accept();
      send(16'h4000, 16'h4000, 1'b0, 1'b0, pk(16'h8000, 1'b0, 1'b1));
      drain();
      check("stall_delivered", xfer_cyc.size(), 32'd4);

      // 6: reset with two beats in flight.
      out_ready = 1'b0;
      send(16'h0001, 16'h0002, 1'b0, 1'b0, pk(16'h0003, 1'b0, 1'b0));
      send(16'h0004, 16'h0005, 1'b0, 1'b0, pk(16'h0009, 1'b0, 1'b0));
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
      rst       = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("mid_rst_outputs", {14'd0, ovf, cout, sum}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("no_stale", {31'd0, out_valid}, 32'd0);
      end
      @(posedge clk);
      #1;

      // Random stream with random backpressure, checked against the model.
      fork
         begin
            for (int i = 0; i < 400; i++) begin
               logic [15:0] x;
               logic [15:0] y;
               logic        ci;
               logic        s;
               x  = 16'($urandom);
               y  = 16'($urandom);
               ci = 1'($urandom);
               s  = 1'($urandom);
               if ($urandom_range(0, 3) == 0) begin
                  @(posedge clk);
                  #1;
               end
               send(x, y, ci, s, model(x, y, ci, s));
            end
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk);
               #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      out_ready = 1'b1;
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
